tx232_bcd_frame_tx: RTL and testbench
=====================================

// Module: tx232_bcd_frame_tx
// PURPOSE
//  Parametrised BCD-to-ASCII frame sender; feeds the byte-wide UART transmitter in the tx232 path.
//  On start, sends DIGITS digits of a packed BCD word, MSD first, as ASCII. Optional leading-zero
//  suppression, optional CR/LF terminator. One byte in flight at a time, paced by the tx-done signal.
//  Adds invalid-digit substitution and a tx-done watchdog with error reporting.
// PARAMETERS
//  DIGITS     4     number of BCD digits in bcd (1..8)
//  TERM_MODE  2     terminator: 0 none, 1 CR, 2 CR+LF
//  TIMEOUT    50000 clk cycles to wait for txck rise after tnpd before aborting (>=4)
// PORTS
//  clk    in   1          system clock, all logic on posedge
//  rst    in   1          asynchronous reset, active low
//  bcd    in   4*DIGITS   packed BCD value, digit DIGITS-1 in MSBs; sampled only on accepted start
//  start  in   1          frame request; level-sampled, accepted only in IDLE
//  lzs    in   1          leading-zero suppression; sampled with bcd
//  txck   in   1          UART byte-done; rising edge = previous byte finished (same clock domain)
//  txpd   out  8          byte to UART; valid while tnpd=1, held until the next byte
//  tnpd   out  1          one-cycle load strobe to UART
//  busy   out  1          high from accepted start until return to IDLE
//  done   out  1          one-cycle pulse at frame end, normal or aborted
//  err    out  1          sticky: invalid digit or timeout in current frame; cleared on accepted start
// BEHAVIOUR
//  Reset: state IDLE; txpd=8'h00, tnpd=0, busy=0, done=0, err=0; edge-detect history, counters cleared.
//  Reset mid-frame aborts at once; no done pulse; next start sends a full frame.
//  Edge detect: txck_d <= {txck_d[0], txck}; txck_r = txck_d[0] & ~txck_d[1] (1-cycle latency).
//  txck_r is consumed only in WAIT; edges in any other state are discarded.
//  FSM: IDLE -> LOAD -> SEND -> WAIT -> (SEND | DONE) -> IDLE.
//   IDLE: start=1 latches bcd and lzs, clears err, sets busy -> LOAD.
//   LOAD: sets the digit index to DIGITS-1. With lzs=1, skips to the highest nonzero digit;
//         digit 0 is always sent (all-zero value sends one '0'). Builds byte count
//         = sent digits + TERM_MODE -> SEND.
//   SEND: txpd <= current byte, tnpd=1 for exactly this cycle, watchdog cleared -> WAIT.
//   WAIT: txck_r -> advance index, then SEND if bytes remain, else DONE.
//         Watchdog reaches TIMEOUT -> err=1 -> DONE (remaining bytes dropped).
//   DONE: done=1 for one cycle, busy=0 on exit -> IDLE. start in DONE is ignored.
//  Timing: tnpd rises 2 clocks after the accepted-start edge. Each later tnpd follows
//   a txck rise by 3 clocks.
//  Byte map: digit 0..9 -> 8'h30+d. Nibble >9 -> 8'h3F ('?') and err=1; the frame continues.
//   Terminator order is CR (8'h0D), then LF (8'h0A).
//  start while busy: ignored, no queuing. Latched data is immune to bcd changes mid-frame.
//  Widths: index 3 bits, byte counter 4 bits (max 8+2=10), watchdog $clog2(TIMEOUT+1) bits, saturating.
// STRUCTURE
//  Package tx232_pkg:
//   - state enum IDLE/LOAD/SEND/WAIT/DONE
//   - ASCII_0=8'h30, ASCII_CR=8'h0D, ASCII_LF=8'h0A, ASCII_ERR=8'h3F
//   - TERM_NONE/CR/CRLF codes
//  Sub-module tx232_edge_det: 2-bit txck history with rising-edge pulse, clk/rst as above.
//  Remaining datapath (digit mux, byte select, counters) stays in this module.
// TESTING (DIGITS=4, TERM_MODE=2, TIMEOUT=64; bench UART model raises txck 20 clk after each tnpd)
//  1 bcd=16'h1234, lzs=0, start -> txpd 31,32,33,34,0D,0A on 6 tnpd pulses. done once, err=0, busy low after done.
//  2 bcd=16'h0042, lzs=1 -> 34,32,0D,0A. bcd=16'h0000, lzs=1 -> 30,0D,0A. bcd=16'h0042, lzs=0 -> 30,30,34,32,0D,0A.
//  3 bcd=16'h12A4 -> 31,32,3F,34,0D,0A, err=1 after 3rd byte. The next valid start clears err.
//  4 UART model silent after 1st tnpd -> err=1 and done 64..66 clk after tnpd. No further tnpd; busy=0.
//  5 start held high for a whole frame and bcd changed mid-frame -> frame uses the latched value;
//    a new frame starts only after IDLE is re-entered. A txck pulse injected in IDLE produces no tnpd.
//  6 rst low after the 2nd byte -> all outputs 0 next cycle, no done. Release, start bcd=16'h9876
//    -> 39,38,37,36,0D,0A.

Source files
------------

// File: rtl/tx232_pkg.sv
// Shared types and constants for the tx232 BCD frame sender.
// Holds the FSM state encoding, the ASCII byte codes and the terminator mode codes.
package tx232_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    SEND = 3'd2,
    WAIT = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [7:0] ASCII_0   = 8'h30;
  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_LF  = 8'h0A;
  localparam logic [7:0] ASCII_ERR = 8'h3F;

  localparam int TERM_NONE = 0;
  localparam int TERM_CR   = 1;
  localparam int TERM_CRLF = 2;

  function automatic logic digit_valid(input logic [3:0] nib);
    return (nib <= 4'd9);
  endfunction

  // Nibbles above 9 are replaced by '?' so the frame still has a fixed shape.
  function automatic logic [7:0] digit_ascii(input logic [3:0] nib);
    if (digit_valid(nib)) begin
      return ASCII_0 + {4'h0, nib};
    end
    return ASCII_ERR;
  endfunction

endpackage

// File: rtl/tx232_edge_det.sv
// Rising-edge detector for the UART byte-done line.
// Two-stage history; the pulse lags the input by one clock.
module tx232_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise
);

  logic [1:0] hist;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist <= 2'b00;
    end else begin
      hist <= {hist[0], sig};
    end
  end

  assign rise = hist[0] & ~hist[1];

endmodule

// File: rtl/tx232_bcd_frame_tx.sv
// BCD-to-ASCII frame sender for the tx232 UART path: digits MSD first, optional
// leading-zero suppression, optional CR/LF, one byte in flight, tx-done watchdog.
module tx232_bcd_frame_tx
  import tx232_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int TERM_MODE = 2,
  parameter int TIMEOUT   = 50000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4*DIGITS-1:0] bcd,
  input  logic                start,
  input  logic                lzs,
  input  logic                txck,
  output logic [7:0]          txpd,
  output logic                tnpd,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int              BW         = 4 * DIGITS;
  localparam int              WDW        = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0]  WD_LIMIT   = WDW'(TIMEOUT);
  localparam logic [3:0]      TERM_BYTES = 4'(TERM_MODE);

  state_t          state;
  state_t          state_nx;
  logic [BW-1:0]   bcd_lat;
  logic            lzs_lat;
  logic [2:0]      dig_idx;
  logic [3:0]      byte_rem;
  logic [WDW-1:0]  wd_cnt;
  logic            txck_r;

  logic [2:0]      top_idx;
  logic [BW-1:0]   bcd_sh;
  logic [3:0]      nib;
  logic            cur_is_digit;
  logic [7:0]      cur_byte;
  logic            wd_expired;

  tx232_edge_det u_edge_det (
    .clk  (clk),
    .rst  (rst),
    .sig  (txck),
    .rise (txck_r)
  );

  // Handshake: txpd is loaded and tnpd pulses for one clock in the same cycle; txpd
  // then holds until the next load. The next byte is only issued after a txck rising
  // edge seen while waiting, so exactly one byte is outstanding at the UART.

  // Highest digit that will be sent; digit 0 always goes out, even for an all-zero value.
  always_comb begin
    top_idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!lzs_lat || (bcd_lat[4*i +: 4] != 4'h0)) begin
        top_idx = 3'(i);
      end
    end
  end

  // byte_rem counts the current byte too, so the last TERM_MODE values select terminators.
  always_comb begin
    bcd_sh       = bcd_lat >> {dig_idx, 2'b00};
    nib          = bcd_sh[3:0];
    cur_is_digit = (byte_rem > TERM_BYTES);
    if (cur_is_digit) begin
      cur_byte = digit_ascii(nib);
    end else if ((TERM_MODE == TERM_CRLF) && (byte_rem == 4'd2)) begin
      cur_byte = ASCII_CR;
    end else if (TERM_MODE == TERM_CRLF) begin
      cur_byte = ASCII_LF;
    end else begin
      cur_byte = ASCII_CR;
    end
  end

  assign wd_expired = (wd_cnt >= WD_LIMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = LOAD;
        end
      end
      LOAD: state_nx = SEND;
      SEND: state_nx = WAIT;
      WAIT: begin
        if (txck_r) begin
          state_nx = (byte_rem > 4'd1) ? SEND : DONE;
        end else if (wd_expired) begin
          state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcd_lat  <= '0;
      lzs_lat  <= 1'b0;
      dig_idx  <= '0;
      byte_rem <= '0;
      wd_cnt   <= '0;
      txpd     <= 8'h00;
      tnpd     <= 1'b0;
      err      <= 1'b0;
    end else begin
      tnpd <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bcd_lat <= bcd;
            lzs_lat <= lzs;
            err     <= 1'b0;
          end
        end
        LOAD: begin
          dig_idx  <= top_idx;
          byte_rem <= {1'b0, top_idx} + 4'd1 + TERM_BYTES;
        end
        SEND: begin
          txpd   <= cur_byte;
          tnpd   <= 1'b1;
          wd_cnt <= '0;
          if (cur_is_digit && !digit_valid(nib)) begin
            err <= 1'b1;
          end
        end
        WAIT: begin
          if (txck_r) begin
            byte_rem <= byte_rem - 4'd1;
            if (cur_is_digit && (dig_idx != 3'd0)) begin
              dig_idx <= dig_idx - 3'd1;
            end
          end else if (wd_expired) begin
            err <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + WDW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_tx232_bcd_frame_tx.sv
// Self-checking bench for tx232_bcd_frame_tx: table vectors, hand-written corner
// sequences and randomized frames checked against a digit-list reference model.
module tb_tx232_bcd_frame_tx;

  localparam int DIGITS    = 4;
  localparam int TERM_MODE = 2;
  localparam int TIMEOUT   = 64;
  localparam int UART_LAT  = 20;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] bcd = '0;
  logic        start = 1'b0;
  logic        lzs = 1'b0;
  logic        txck = 1'b0;
  logic [7:0]  txpd;
  logic        tnpd;
  logic        busy;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  tx232_bcd_frame_tx #(
    .DIGITS    (DIGITS),
    .TERM_MODE (TERM_MODE),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bcd   (bcd),
    .start (start),
    .lzs   (lzs),
    .txck  (txck),
    .txpd  (txpd),
    .tnpd  (tnpd),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int         n_vec = 0;
  int         n_bad = 0;
  logic [7:0] exp_q[$];
  logic       exp_err;
  logic [7:0] got_q[$];
  int         tnpd_cyc_q[$];
  logic       err_q[$];
  int         done_cnt = 0;
  int         done_cyc = 0;
  logic       err_at_done = 1'b0;
  bit         uart_en = 1'b1;
  int         uart_cnt = 0;
  int         uart_hold = 0;
  int         start_cyc = 0;

  typedef struct {
    logic [15:0] bcd;
    logic        lzs;
    int          n;
    logic [7:0]  b[6];
    logic        err;
  } vec_t;

  vec_t tbl[6];

  // Monitor plus UART model: txck rises UART_LAT clocks after each tnpd, held 2 clocks.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        uart_cnt  = 0;
        uart_hold = 0;
        txck      = 1'b0;
      end else begin
        if (uart_hold > 0) begin
          uart_hold--;
          if (uart_hold == 0) txck = 1'b0;
        end
        if (uart_cnt > 0) begin
          uart_cnt--;
          if (uart_cnt == 0) begin
            txck      = 1'b1;
            uart_hold = 2;
          end
        end
        if (tnpd && uart_en) uart_cnt = UART_LAT;
      end
      if (tnpd) begin
        got_q.push_back(txpd);
        tnpd_cyc_q.push_back(cyc);
        err_q.push_back(err);
      end
      if (done) begin
        done_cnt++;
        done_cyc    = cyc;
        err_at_done = err;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, required finish");
    $fatal(1);
  end

  // ---------------- driver / check tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp_v);
    end
  endtask

  task automatic clear_capture();
    got_q.delete();
    tnpd_cyc_q.delete();
    err_q.delete();
    done_cnt = 0;
  endtask

  task automatic start_frame(input logic [15:0] b, input logic l);
    for (int k = 0; k < 500 && busy; k++) tick();
    check("idle_before_start", 32'(busy), 32'd0);
    clear_capture();
    bcd       = b;
    lzs       = l;
    start     = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("err_cleared_on_start", 32'(err), 32'd0);
  endtask

  task automatic wait_done_cnt(input int n);
    for (int k = 0; k < 3000 && done_cnt < n; k++) tick();
    check("done_seen", 32'(done_cnt >= n), 32'd1);
  endtask

  task automatic check_frame(input string name);
    check($sformatf("%s nbytes", name), 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size())
        check($sformatf("%s byte%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
    end
    check($sformatf("%s err", name), 32'(err_at_done), 32'(exp_err));
    check($sformatf("%s done_once", name), 32'(done_cnt), 32'd1);
    tick();
    check($sformatf("%s busy_low", name), 32'(busy), 32'd0);
  endtask

  // Reference model: list of digits, strip leading zeros if asked, map, then CR LF.
  function automatic void model_frame(input logic [15:0] b, input logic l);
    int d[DIGITS];
    int top;
    exp_q.delete();
    exp_err = 1'b0;
    for (int i = 0; i < DIGITS; i++) d[i] = (int'(b) >> (4 * i)) % 16;
    top = DIGITS - 1;
    if (l) begin
      while (top > 0 && d[top] == 0) top--;
    end
    for (int i = top; i >= 0; i--) begin
      if (d[i] > 9) begin
        exp_q.push_back(8'h3F);
        exp_err = 1'b1;
      end else begin
        exp_q.push_back(8'h30 + 8'(d[i]));
      end
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    logic [15:0] rb;
    logic        rl;
    int          keep;
    int          n0;
    int          lat;

    tbl[0] = '{16'h1234, 1'b0, 6, '{8'h31, 8'h32, 8'h33, 8'h34, 8'h0D, 8'h0A}, 1'b0};
    tbl[1] = '{16'h0042, 1'b1, 4, '{8'h34, 8'h32, 8'h0D, 8'h0A, 8'h00, 8'h00}, 1'b0};
    tbl[2] = '{16'h0000, 1'b1, 3, '{8'h30, 8'h0D, 8'h0A, 8'h00, 8'h00, 8'h00}, 1'b0};
    tbl[3] = '{16'h0042, 1'b0, 6, '{8'h30, 8'h30, 8'h34, 8'h32, 8'h0D, 8'h0A}, 1'b0};
    tbl[4] = '{16'h12A4, 1'b0, 6, '{8'h31, 8'h32, 8'h3F, 8'h34, 8'h0D, 8'h0A}, 1'b1};
    tbl[5] = '{16'h5678, 1'b1, 6, '{8'h35, 8'h36, 8'h37, 8'h38, 8'h0D, 8'h0A}, 1'b0};

    rst = 1'b0;
    repeat (3) tick();
    check("reset txpd", 32'(txpd), 32'h00);
    check("reset tnpd", 32'(tnpd), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset err", 32'(err), 32'd0);
    rst = 1'b1;
    repeat (2) tick();

    // Table-driven frames, including timing of first byte and byte spacing.
    for (int t = 0; t < 6; t++) begin
      exp_q.delete();
      for (int i = 0; i < tbl[t].n; i++) exp_q.push_back(tbl[t].b[i]);
      exp_err = tbl[t].err;
      start_frame(tbl[t].bcd, tbl[t].lzs);
      wait_done_cnt(1);
      if (tnpd_cyc_q.size() >= 2) begin
        check($sformatf("tbl%0d first_tnpd_lat", t), 32'(tnpd_cyc_q[0] - start_cyc), 32'd3);
        check($sformatf("tbl%0d tnpd_gap", t), 32'(tnpd_cyc_q[1] - tnpd_cyc_q[0]), 32'(UART_LAT + 3));
      end else begin
        check($sformatf("tbl%0d tnpd_count", t), 32'(tnpd_cyc_q.size()), 32'd2);
      end
      if (tbl[t].err && err_q.size() >= 3) begin
        check($sformatf("tbl%0d err_before_bad", t), 32'(err_q[1]), 32'd0);
        check($sformatf("tbl%0d err_at_bad", t), 32'(err_q[2]), 32'd1);
      end
      check_frame($sformatf("tbl%0d", t));
    end

    // Silent UART after the first byte: watchdog abort.
    uart_en = 1'b0;
    start_frame(16'h1234, 1'b0);
    wait_done_cnt(1);
    check("to nbytes", 32'(got_q.size()), 32'd1);
    if (got_q.size() >= 1) begin
      check("to byte0", 32'(got_q[0]), 32'h31);
      lat = done_cyc - tnpd_cyc_q[0];
      check("to done_latency_64_66", 32'(lat >= 64 && lat <= 66), 32'd1);
    end
    check("to err", 32'(err_at_done), 32'd1);
    repeat (30) tick();
    check("to no_more_bytes", 32'(got_q.size()), 32'd1);
    check("to busy_low", 32'(busy), 32'd0);
    check("to err_sticky", 32'(err), 32'd1);
    uart_en = 1'b1;

    // start held high through a frame, bcd changed mid-frame.
    clear_capture();
    bcd   = 16'h1234;
    lzs   = 1'b0;
    start = 1'b1;
    tick();
    repeat (5) tick();
    bcd = 16'h9999;
    wait_done_cnt(1);
    exp_q   = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h0D, 8'h0A};
    check("hold nbytes1", 32'(got_q.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      if (i < got_q.size()) check($sformatf("hold f1 byte%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
    tick();
    check("hold idle_between", 32'(busy), 32'd0);
    tick();
    check("hold restart", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done_cnt(2);
    exp_q = '{8'h39, 8'h39, 8'h39, 8'h39, 8'h0D, 8'h0A};
    check("hold nbytes2", 32'(got_q.size()), 32'd12);
    for (int i = 0; i < 6; i++)
      if (i + 6 < got_q.size()) check($sformatf("hold f2 byte%0d", i), 32'(got_q[i + 6]), 32'(exp_q[i]));
    repeat (2) tick();

    // txck edge in IDLE must not trigger a byte.
    n0   = got_q.size();
    txck = 1'b1;
    repeat (2) tick();
    txck = 1'b0;
    repeat (30) tick();
    check("idle_txck no_tnpd", 32'(got_q.size()), 32'(n0));
    check("idle_txck busy", 32'(busy), 32'd0);

    // Reset mid-frame after the second byte.
    start_frame(16'h1234, 1'b0);
    for (int k = 0; k < 200 && got_q.size() < 2; k++) tick();
    check("rst two_bytes_seen", 32'(got_q.size()), 32'd2);
    rst = 1'b0;
    tick();
    check("rst txpd", 32'(txpd), 32'h00);
    check("rst tnpd", 32'(tnpd), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst err", 32'(err), 32'd0);
    repeat (5) tick();
    check("rst no_done", 32'(done_cnt), 32'd0);
    rst = 1'b1;
    tick();
    model_frame(16'h9876, 1'b0);
    start_frame(16'h9876, 1'b0);
    wait_done_cnt(1);
    check_frame("after_rst");

    // Randomized frames against the reference model.
    for (int r = 0; r < 20; r++) begin
      keep = $urandom_range(0, DIGITS);
      rb   = '0;
      for (int i = 0; i < DIGITS; i++) begin
        if (i < keep) begin
          if ($urandom_range(0, 7) == 0) rb[4*i +: 4] = 4'($urandom_range(10, 15));
          else rb[4*i +: 4] = 4'($urandom_range(0, 9));
        end
      end
      rl = 1'($urandom_range(0, 1));
      model_frame(rb, rl);
      start_frame(rb, rl);
      wait_done_cnt(1);
      check_frame($sformatf("rnd%0d bcd=%h lzs=%0d", r, rb, rl));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
